dmem_access_ctrl: RTL

//  Sequences and shares the single-port data memory between two requesters:

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_rr_arbiter.sv | 42 ++++
 rtl/dmem_access_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and small helpers for the data-memory
// access controller.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    function automatic logic [1:0] port_bit(input logic id);
        return (id == PORT_DBG) ? 2'b10 : 2'b01;
    endfunction

    // Misalignment, unsupported size, or address bits above the backed range.
    function automatic logic req_error(input logic [1:0]  size,
                                       input logic [31:0] addr,
                                       input logic [31:0] hi_mask);
        logic err;
        case (size)
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = addr[0];
            SIZE_WORD: err = (addr[1:0] != 2'b00);
            default:   err = 1'b1;
        endcase
        return err | ((addr & hi_mask) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Two-way request arbiter: round-robin against the last grant, or fixed
// priority to the core port.
module dmem_rr_arbiter
    import dmem_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    // Grant selection from the current request pattern
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = PORT_CORE;
        case (req_valid)
            2'b01: begin
                grant_valid = 1'b1;
                grant_id    = PORT_CORE;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_id    = PORT_DBG;
            end
            2'b11: begin
                grant_valid = 1'b1;
                if (RR_EN) begin
                    grant_id = ~last_grant;
                end else begin
                    grant_id = PORT_CORE;
                end
            end
            default: begin
                grant_valid = 1'b0;
                grant_id    = PORT_CORE;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Shares the single-port data memory between the core LSU (port 0) and the
// loader/debug port (port 1); one transaction in flight at a time.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter bit RR_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    input  logic [1:0]  req_unsigned,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic        mem_unsigned,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] HI_MASK = ~((32'd1 << ADDR_BITS) - 32'd1);

    state_t      state_r;
    state_t      next_state_s;
    logic        last_grant_r;
    logic        port_r;
    logic        we_r;
    logic        grant_valid_s;
    logic        grant_id_s;
    logic        accept_s;
    logic        rsp_done_s;
    logic        sel_we_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic [1:0]  sel_size_s;
    logic        sel_uns_s;
    logic        sel_err_s;

    logic [1:0]  rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;
    logic [31:0] mem_address_r;
    logic [31:0] mem_write_data_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic [1:0]  mem_size_r;
    logic        mem_unsigned_r;

    dmem_rr_arbiter #(
        .RR_EN (RR_EN)
    ) u_arb (
        .req_valid   (req_valid),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    // Route the granted port's request fields and classify it
    always_comb begin
        if (grant_id_s == PORT_DBG) begin
            sel_we_s    = req_we[1];
            sel_addr_s  = req_addr[63:32];
            sel_wdata_s = req_wdata[63:32];
            sel_size_s  = req_size[3:2];
            sel_uns_s   = req_unsigned[1];
        end else begin
            sel_we_s    = req_we[0];
            sel_addr_s  = req_addr[31:0];
            sel_wdata_s = req_wdata[31:0];
            sel_size_s  = req_size[1:0];
            sel_uns_s   = req_unsigned[0];
        end
        sel_err_s = req_error(sel_size_s, sel_addr_s, HI_MASK);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; rejected requests skip the memory cycle
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = sel_err_s ? ST_RESP : ST_ACCESS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: next_state_s = ST_RESP;
            ST_RESP: begin
                if (rsp_done_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Handshake decode per state; ready is offered to the granted port only
    always_comb begin
        req_ready  = 2'b00;
        accept_s   = 1'b0;
        rsp_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    req_ready = port_bit(grant_id_s);
                    accept_s  = 1'b1;
                end else begin
                    req_ready = 2'b00;
                    accept_s  = 1'b0;
                end
            end
            ST_RESP:  rsp_done_s = rsp_ready[port_r];
            default: begin
                req_ready  = 2'b00;
                accept_s   = 1'b0;
                rsp_done_s = 1'b0;
            end
        endcase
    end

    // Request latch, memory-side registers and response register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_r     <= PORT_DBG;
            port_r           <= PORT_CORE;
            we_r             <= 1'b0;
            rsp_valid_r      <= 2'b00;
            rsp_rdata_r      <= 32'd0;
            rsp_err_r        <= 1'b0;
            mem_address_r    <= 32'd0;
            mem_write_data_r <= 32'd0;
            mem_read_r       <= 1'b0;
            mem_write_r      <= 1'b0;
            mem_size_r       <= 2'b00;
            mem_unsigned_r   <= 1'b0;
        end else begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            if (accept_s) begin
                port_r       <= grant_id_s;
                we_r         <= sel_we_s;
                last_grant_r <= grant_id_s;
                rsp_err_r    <= sel_err_s;
                rsp_rdata_r  <= 32'd0;
                if (sel_err_s) begin
                    rsp_valid_r <= port_bit(grant_id_s);
                end else begin
                    // Buses only move on a real access so the memory never sees a rejected address
                    mem_address_r    <= sel_addr_s;
                    mem_write_data_r <= sel_wdata_s;
                    mem_size_r       <= sel_size_s;
                    mem_unsigned_r   <= sel_uns_s;
                    mem_read_r       <= ~sel_we_s;
                    mem_write_r      <= sel_we_s;
                end
            end else if (state_r == ST_ACCESS) begin
                rsp_valid_r <= port_bit(port_r);
                rsp_rdata_r <= we_r ? 32'd0 : mem_read_data;
            end else if (rsp_done_s) begin
                rsp_valid_r <= 2'b00;
            end
        end
    end

    assign rsp_valid      = rsp_valid_r;
    assign rsp_rdata      = rsp_rdata_r;
    assign rsp_err        = rsp_err_r;
    assign mem_address    = mem_address_r;
    assign mem_write_data = mem_write_data_r;
    assign mem_read       = mem_read_r;
    assign mem_write      = mem_write_r;
    assign mem_size       = mem_size_r;
    assign mem_unsigned   = mem_unsigned_r;

endmodule
